// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with a same-cycle hit lookup and a
// single-line refill engine on a valid/ready word request channel.
module instruction_cache #(
    parameter int LineWords = 4,
    parameter int LineCount = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_valid_o,
    input  logic        invalidate_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_address_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
);
    localparam int OB = $clog2(LineWords);
    localparam int IB = $clog2(LineCount);
    localparam int TW = 32 - OB - IB - 2;
    localparam int CW = OB + 1;
    localparam logic [CW-1:0] CntFull = CW'(LineWords);
    localparam logic [CW-1:0] CntLast = CW'(LineWords - 1);
    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [LineCount-1:0] valid_q;
    logic [TW-1:0] tag_array [LineCount];
    logic [31:0] data_array [LineCount][LineWords];

    logic [31:0] base_q;
    logic [IB-1:0] refill_index;
    logic [CW-1:0] req_count;
    logic [CW-1:0] resp_count;
    logic inval_pending;

    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TW-1:0] tag;
    logic lookup_match;
    logic hit;
    logic start_refill;
    logic req_fire;
    logic resp_fire;
    logic refill_done;
    logic unused_bits;

    assign offset = read_address_i[OB+1:2];
    assign index = read_address_i[OB+IB+1:OB+2];
    assign tag = read_address_i[31:OB+IB+2];
    assign unused_bits = ^read_address_i[1:0];

    assign lookup_match = valid_q[index] && (tag_array[index] == tag);

    always_comb begin
        state_next = state;
        hit = 1'b0;
        start_refill = 1'b0;
        req_fire = 1'b0;
        resp_fire = 1'b0;
        refill_done = 1'b0;
        mem_req_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                hit = lookup_match && !invalidate_i;
                if (!invalidate_i && !lookup_match) begin
                    start_refill = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                mem_req_valid_o = req_count < CntFull;
                req_fire = mem_req_valid_o && mem_req_ready_i;
                resp_fire = mem_resp_valid_i;
                if (resp_fire && resp_count == CntLast) begin
                    refill_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read_valid_o = hit;
    assign read_data_o = hit ? data_array[index][offset] : Nop;
    assign mem_req_address_o = base_q
        + {{(32-CW-2){1'b0}}, req_count, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            base_q <= '0;
            refill_index <= '0;
            req_count <= '0;
            resp_count <= '0;
            inval_pending <= 1'b0;
        end else begin
            if (start_refill) begin
                base_q <= {read_address_i[31:OB+2], {(OB+2){1'b0}}};
                refill_index <= index;
                req_count <= '0;
                resp_count <= '0;
                valid_q[index] <= 1'b0;
            end
            if (req_fire) begin
                req_count <= req_count + CW'(1);
            end
            if (resp_fire) begin
                resp_count <= resp_count + CW'(1);
            end
            if (state == IDLE && invalidate_i) begin
                valid_q <= '0;
            end
            if (state == REFILL && invalidate_i) begin
                inval_pending <= 1'b1;
            end
            // A flush seen at any point of the refill wins over the new line
            if (refill_done) begin
                if (inval_pending || invalidate_i) begin
                    valid_q <= '0;
                end else begin
                    valid_q[refill_index] <= 1'b1;
                end
                inval_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_refill && !rst_i) begin
            tag_array[index] <= tag;
        end
        if (resp_fire && !rst_i) begin
            data_array[refill_index][resp_count[OB-1:0]] <= mem_resp_data_i;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: line-level reference model,
// memory responder with backpressure/latency modes, decoupled monitor.
module tb_instruction_cache;
    localparam int LW = 4;
    localparam int LC = 64;
    localparam int OB = $clog2(LW);
    localparam int IB = $clog2(LC);
    localparam logic [31:0] LB = 32'(4 * LW);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic read_valid;
    logic invalidate = 1'b0;
    logic mem_req_valid;
    logic mem_req_ready = 1'b0;
    logic [31:0] mem_req_address;
    logic mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    instruction_cache #(.LineWords(LW), .LineCount(LC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .read_address_i(read_address),
        .read_data_o(read_data),
        .read_valid_o(read_valid),
        .invalidate_i(invalidate),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_address_o(mem_req_address),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit hit;
        int start;
        bit exact;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int due;
    } pend_t;

    exp_t exp_q[$];
    logic [31:0] req_q[$];
    pend_t pend_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_resp_cyc = -1;
    bit rst_q = 1'b0;
    int delay_mode = 0;
    int bp_idx = 0;
    bit stall_prev = 1'b0;
    logic [31:0] stall_addr = '0;

    bit m_valid[LC];
    logic [31:0] m_line[LC];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_clear();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_q <= rst;
    end

    // Memory responder: in-order words, configurable ready and latency
    pend_t rp;
    int dly;
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (delay_mode == 1) begin
                mem_req_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
                bp_idx++;
                dly = 3;
            end else if (delay_mode == 2) begin
                mem_req_ready = 1'($urandom_range(0, 1));
                dly = int'($urandom_range(0, 3));
            end else begin
                mem_req_ready = 1'b1;
                dly = 0;
            end
            if (stall_prev) begin
                check("req_hold_valid", 32'(mem_req_valid), 32'd1);
                check("req_hold_addr", mem_req_address, stall_addr);
            end
            stall_prev = mem_req_valid && !mem_req_ready;
            stall_addr = mem_req_address;
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=%h required=none",
                             mem_req_address);
                end else begin
                    check("req_addr", mem_req_address, req_q.pop_front());
                end
                rp.addr = mem_req_address;
                rp.due = cyc + dly;
                pend_q.push_back(rp);
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rp = pend_q.pop_front();
                mem_resp_valid = 1'b1;
                mem_resp_data = mem_word(rp.addr);
                last_resp_cyc = cyc;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data = $urandom;
            end
        end
    end

    // Monitor: compares every presented hit against the scoreboard head
    exp_t me;
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                check("rst_req_valid", 32'(mem_req_valid), 32'd0);
                check("rst_req_addr", mem_req_address, 32'd0);
                check("rst_read_valid", 32'(read_valid), 32'd0);
            end
            if (!read_valid) begin
                check("nop_on_miss", read_data, NOP);
            end
            if (exp_q.size() == 0) begin
                check("no_hit_expected", 32'(read_valid), 32'd0);
            end else begin
                if (exp_q[0].hit && cyc == exp_q[0].start) begin
                    check("hit_now", 32'(read_valid), 32'd1);
                end
                if (read_valid) begin
                    me = exp_q.pop_front();
                    check("hit_data", read_data, me.data);
                    if (me.hit) begin
                        check("hit_cycle", 32'(cyc), 32'(me.start));
                    end else begin
                        check("fill_done_cycle", 32'(cyc),
                              32'(last_resp_cyc + 1));
                        if (me.exact) begin
                            check("miss_latency", 32'(cyc - me.start),
                                  32'(LW + 1));
                        end
                    end
                end
            end
        end
    end

    // Predict hit/miss and the refill request stream at line granularity
    task automatic fetch(input logic [31:0] a, input int refills);
        logic [31:0] line;
        int idx;
        bit h;
        exp_t e;
        line = a / LB;
        idx = int'(line % LC);
        h = m_valid[idx] && (m_line[idx] == line);
        if (!h) begin
            for (int r = 0; r < refills; r++) begin
                for (int k = 0; k < LW; k++) begin
                    req_q.push_back(line * LB + 32'(4 * k));
                end
            end
            m_valid[idx] = 1'b1;
            m_line[idx] = line;
        end
        e.data = mem_word(a);
        e.hit = h;
        e.start = cyc;
        e.exact = !h && refills == 1 && delay_mode == 0;
        exp_q.push_back(e);
        read_address = a;
    endtask

    task automatic wait_hit();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!read_valid && n < 300);
        if (!read_valid) begin
            checks++;
            failures++;
            $display("FAIL hit_timeout actual=no_hit required=hit addr=%h",
                     read_address);
            exp_q.delete();
            req_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [31:0] a);
        fetch(a, 1);
        wait_hit();
    endtask

    task automatic inval_idle(input logic [31:0] a);
        read_address = a;
        invalidate = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        invalidate = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        access(32'h100);
        access(32'h10C);
        access(32'h108);

        access(32'h500);
        access(32'h50C);
        access(32'h100);

        delay_mode = 1;
        access(32'h204);
        access(32'h208);
        delay_mode = 0;

        inval_idle(32'h100);
        access(32'h100);

        // Flush at the second response: line refilled twice before a hit
        fetch(32'h304, 2);
        step();
        step();
        invalidate = 1'b1;
        model_clear();
        m_valid[(32'h304 / LB) % LC] = 1'b1;
        step();
        invalidate = 1'b0;
        wait_hit();
        access(32'h100);

        inval_idle(32'h100);
        fetch(32'h100, 1);
        step();
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        req_q.delete();
        model_clear();
        step();
        rst = 1'b0;
        access(32'h100);
        access(32'h104);

        delay_mode = 2;
        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(0, 2)) << (2 + OB + IB))
              | (32'($urandom_range(0, 3)) << (2 + OB))
              | (32'($urandom_range(0, LW - 1)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                inval_idle(a);
            end
            access(a);
        end
        delay_mode = 0;
        access(32'h0000_0404);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
